// File: rtl/arb_requester_pkg.sv
// rtl/arb_requester_pkg.sv - shared types, constants and width helper for the arbiter requester agent
//
// Package arb_pkg:
//   arb_req_state_t : requester FSM states (IDLE, REQ, REL)
//   NUM_REQ         : number of requesters served by the round-robin arbiter
//   clog2()         : ceiling log2, used to size FIFO pointers, counts and counters

package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } arb_req_state_t;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_requester_fifo.sv
// rtl/arb_requester_fifo.sv - synchronous FIFO buffering producer words for the requester agent
//
// Module arb_req_fifo
//   Parameters: DATA_W (word width), FIFO_DEPTH (entries, power of two, >= 2)
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset, empties the FIFO
//   push  in   write din at the tail (ignored when full)
//   pop   in   drop the head entry (ignored when empty)
//   din   in   word to write
//   dout  out  current head, valid whenever empty is low
//   full  out  count == FIFO_DEPTH
//   empty out  count == 0
//   count out  number of stored words

module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("arb_req_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester-side agent for the 4-way round-robin arbiter
//
// Buffers producer words, requests the shared bus while data is queued and,
// once granted, streams up to MAX_BURST beats before releasing the request.
// Optional grant-timeout detection is built when ARB_REQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   wr_valid    in   producer has a word
//   wr_ready    out  FIFO not full
//   wr_data     in   producer word
//   req         out  bus request to the arbiter (high only in REQ)
//   gnt         in   registered grant from the arbiter
//   bus_valid   out  beat on the shared bus this cycle
//   bus_data    out  beat data (FIFO head), zero when no beat
//   busy        out  FSM not idle
//   err_timeout out  sticky grant-timeout flag (0 unless ARB_REQ_TIMEOUT_EN)

module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              busy,
    output logic              err_timeout
);

    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_burst
        $error("arb_requester: MAX_BURST must be in 1..255");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("arb_requester: TIMEOUT must be at least 1");
    end

    arb_req_state_t    state_q;
    arb_req_state_t    state_d;
    logic [7:0]        beat_cnt_q;
    logic [7:0]        beat_cnt_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic              push;
    logic              beat;
    logic              last_beat;

    assign push = wr_valid & ~fifo_full;

    arb_req_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (beat),
        .din   (wr_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A beat needs the grant and data; gnt outside REQ is ignored.
    assign beat = (state_q == REQ) & gnt & ~fifo_empty;

    // Tenure ends at the burst cap or when the word being sent is the last
    // one queued; a word pushed in the same cycle waits for the next tenure.
    assign last_beat = beat & ((beat_cnt_q == 8'(MAX_BURST - 1)) |
                               (fifo_count == CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (last_beat) begin
                    state_d    = REL;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            REL: begin
                // Waiting for the grant to fall keeps req low for at least two
                // cycles, giving the arbiter time to rotate.
                if (!gnt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // req comes straight from the state register: no path from gnt.
    assign req       = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign wr_ready  = ~fifo_full;
    assign bus_valid = beat;
    assign bus_data  = beat ? fifo_head : '0;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WAIT_W = clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              err_q;
    logic              err_d;

    // REQ is only entered from IDLE, where the counter is held at zero, so
    // it always starts a request from zero. It saturates at TIMEOUT.
    always_comb begin
        wait_d = wait_q;
        if (state_q != REQ) begin
            wait_d = '0;
        end else if (beat) begin
            wait_d = '0;
        end else if (!gnt && (wait_q != WAIT_W'(TIMEOUT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        err_d = err_q | (wait_d == WAIT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the 4-way round-robin arbiter; one instance drives each reqN/gntN pair.
- Buffers outgoing words in a local FIFO and raises req while it has data.
- Once granted, streams up to MAX_BURST words onto the shared bus, then drops req so the arbiter can rotate.
- Sits between a producer (valid/ready push) and the arbitrated shared bus (no backpressure once granted).

Parameters:
- DATA_W, 8, width of data words.
- FIFO_DEPTH, 4, local buffer entries; power of two, at least 2.
- MAX_BURST, 4, maximum beats per tenure; range 1 to 255.
- TIMEOUT, 64, cycles in REQ without gnt before err_timeout is raised (optional feature only).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  FIFO not full.
- wr_data  in  DATA_W  producer word.
- req  out  1  bus request to arbiter reqN.
- gnt  in  1  grant from arbiter gntN; registered on the arbiter side.
- bus_valid  out  1  beat on shared bus this cycle.
- bus_data  out  DATA_W  beat data (FIFO head).
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky grant-timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: state=IDLE, FIFO empty, beat_cnt=0, req=0, bus_valid=0, bus_data=0, busy=0, wr_ready=1, err_timeout=0. Reset mid-tenure drops req immediately (asynchronous) and discards FIFO contents.
- Push: occurs when wr_valid & wr_ready at a clock edge; the count is visible next cycle.
- FSM states: IDLE, REQ, REL. req = (state==REQ), decoded from the state register with no combinational path from gnt.
- IDLE -> REQ at the edge where count != 0.
- In REQ, a beat occurs when gnt=1 and the FIFO is non-empty:
  - bus_valid=1, bus_data=head (bus_valid and bus_data are combinational from state, gnt and FIFO).
  - The head is popped at the edge and beat_cnt increments.
- last = beat & (beat_cnt==MAX_BURST-1 | count==1).
  - A push in the same cycle does not extend the tenure; that word waits for the next tenure.
- REQ -> REL on last. beat_cnt clears on entry to REL.
- REL: req=0, bus_valid=0. Stay while gnt=1. At the edge where gnt=0, go to IDLE. req is therefore low for at least 2 cycles, which lets the arbiter re-evaluate and rotate.
- Grant lost in REQ (gnt=0 after previously 1): no beat and no pop; stay in REQ and keep req high. beat_cnt holds.
- gnt=1 in IDLE or REL: ignored, bus_valid=0.
- Simultaneous push and pop with FIFO full: allowed only if wr_ready was 1. wr_ready=0 when count==FIFO_DEPTH, even if a pop happens that cycle.
- Latency: push at E0, req high after E1, arbiter gnt after E2, first beat in the cycle after E2, i.e. 3 cycles from push edge to first beat.
- Widths: count is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH; beat_cnt is 8 bits.

Optional Feature:
- Macro: ARB_REQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and on any beat, and increments each REQ cycle with gnt=0.
  - When the counter reaches TIMEOUT, err_timeout is set.
  - err_timeout is sticky until rst; it does not alter the FSM.
- Undefined: no counter; err_timeout is constant 0.

Decomposition:
- Package arb_pkg holds:
  - arb_req_state_t enum {IDLE, REQ, REL}.
  - Localparam NUM_REQ=4.
  - Function clog2 used for count and pointer widths.
- One sub-module, arb_req_fifo: synchronous FIFO.
  - Parameters DATA_W, FIFO_DEPTH.
  - Ports push/pop/din/dout/full/empty/count; clk and async active-low rst.
  - dout is the head, visible without a pop.

Test Plan:
- Single word: push 0xA5, gnt driven 1 cycle after req -> exactly one beat with bus_data=0xA5, then REL; req low ≥2 cycles; final state IDLE.
- Burst cap: push 6 words 0x01..0x06 with MAX_BURST=4, gnt held whenever req=1 -> beats 01..04, req drops, re-request, then beats 05..06.
- Grant withdrawn: 3 words queued, gnt high 1 cycle then low 3 cycles then high -> beats 1, 2, 3 in order, no duplication, req held throughout.
- Full FIFO: 4 pushes with gnt=0 -> wr_ready=0 after the 4th; a 5th push is held until the first pop and is then accepted.
- Async reset: assert rst low mid-burst between clock edges -> req, bus_valid and busy drop immediately; FIFO empty after release.
- ARB_REQ_TIMEOUT_EN with TIMEOUT=8: req high, gnt stuck 0 -> err_timeout=1 after 8 cycles and stays 1 after gnt later arrives and data drains.
